// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if
//   Handshake/data bundle between the EX stage and the iterative
//   multiply/divide unit.
//   master : EX-stage side (drives the instruction, observes the result/stall)
//   slave  : the multiply/divide unit
//   VALID_IN/FLUSH_IN/FUNCT3_IN/SRCA_IN/SRCB_IN : instruction and operands
//   RESULT_OUT/DONE_OUT/STALL_OUT/BUSY_OUT       : completion and pipeline control
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             VALID_IN;
    logic             FLUSH_IN;
    logic [2:0]       FUNCT3_IN;
    logic [WIDTH-1:0] SRCA_IN;
    logic [WIDTH-1:0] SRCB_IN;
    logic [WIDTH-1:0] RESULT_OUT;
    logic             DONE_OUT;
    logic             STALL_OUT;
    logic             BUSY_OUT;

    modport master (
        output VALID_IN, FLUSH_IN, FUNCT3_IN, SRCA_IN, SRCB_IN,
        input  RESULT_OUT, DONE_OUT, STALL_OUT, BUSY_OUT
    );

    modport slave (
        input  VALID_IN, FLUSH_IN, FUNCT3_IN, SRCA_IN, SRCB_IN,
        output RESULT_OUT, DONE_OUT, STALL_OUT, BUSY_OUT
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative RV32M multiply/divide unit in the EX stage. One result bit per
//   cycle (radix-2 shift-add multiply, restoring divide), WIDTH cycles per
//   operation, STALL_OUT freezes IF/ID/EX until the one-cycle DONE_OUT pulse.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-low reset
//     bus  : ex_muldiv_unit_if.slave (instruction, operands, result, control)
//   Build option:
//     MULDIV_DIV_EN defined   -> divide/remainder datapath and special cases
//     MULDIV_DIV_EN undefined -> FUNCT3_IN[2]=1 completes in one cycle with 0
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for VALID_IN; operands latched on the starting edge
//   S_CALC | iterating, counter 0..WIDTH-1, result registered on the last
//   S_DONE | DONE_OUT high for one cycle, then back to S_IDLE
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    ex_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    // Shared shift register: {accumulator/remainder, multiplier/quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               a_signed, b_signed, a_neg_in, b_neg_in;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               special;
    logic [WIDTH-1:0]   special_res;
    logic [WIDTH:0]     sum_mul;
    logic [2*WIDTH-1:0] mul_next, step_next, prod_fix;
    logic [WIDTH-1:0]   mul_res, final_res;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     r_shift, diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               div_zero, div_ovf;
`endif

    // Operand conditioning for the starting edge
    always_comb begin
        a_signed = (bus.FUNCT3_IN == 3'd1) || (bus.FUNCT3_IN == 3'd2) ||
                   (bus.FUNCT3_IN == 3'd4) || (bus.FUNCT3_IN == 3'd6);
        b_signed = (bus.FUNCT3_IN == 3'd1) || (bus.FUNCT3_IN == 3'd4) ||
                   (bus.FUNCT3_IN == 3'd6);
        a_neg_in = a_signed & bus.SRCA_IN[WIDTH-1];
        b_neg_in = b_signed & bus.SRCB_IN[WIDTH-1];
        a_mag    = a_neg_in ? -bus.SRCA_IN : bus.SRCA_IN;
        b_mag    = b_neg_in ? -bus.SRCB_IN : bus.SRCB_IN;
`ifdef MULDIV_DIV_EN
        div_zero = (bus.SRCB_IN == '0);
        div_ovf  = ((bus.FUNCT3_IN == 3'd4) || (bus.FUNCT3_IN == 3'd6)) &&
                   (bus.SRCA_IN == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (bus.SRCB_IN == '1);
        special  = bus.FUNCT3_IN[2] & (div_zero | div_ovf);
        // funct3[1] separates REM/REMU from DIV/DIVU
        if (div_zero) begin
            special_res = bus.FUNCT3_IN[1] ? bus.SRCA_IN : '1;
        end else begin
            special_res = bus.FUNCT3_IN[1] ? '0 : bus.SRCA_IN;
        end
`else
        special     = bus.FUNCT3_IN[2];
        special_res = '0;
`endif
    end

    // One iteration of the datapath
    always_comb begin
        sum_mul  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {sum_mul, acc_q[WIDTH-1:1]};
        prod_fix = (a_neg_q ^ b_neg_q) ? -mul_next : mul_next;
        mul_res  = (f3_q == 3'd0) ? prod_fix[WIDTH-1:0]
                                  : prod_fix[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
        r_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff     = r_shift - {1'b0, opb_q};
        // diff[WIDTH] set means the trial subtraction borrowed: restore
        if (!diff[WIDTH]) begin
            div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {r_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        quo_fix   = (a_neg_q ^ b_neg_q) ? -div_next[WIDTH-1:0]
                                        : div_next[WIDTH-1:0];
        rem_fix   = a_neg_q ? -div_next[2*WIDTH-1:WIDTH]
                            : div_next[2*WIDTH-1:WIDTH];
        step_next = f3_q[2] ? div_next : mul_next;
        final_res = f3_q[2] ? (f3_q[1] ? rem_fix : quo_fix) : mul_res;
`else
        step_next = mul_next;
        final_res = mul_res;
`endif
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;

        if (bus.FLUSH_IN) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.VALID_IN) begin
                        f3_d    = bus.FUNCT3_IN;
                        a_neg_d = a_neg_in;
                        b_neg_d = b_neg_in;
                        opb_d   = b_mag;
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        cnt_d   = '0;
                        if (special) begin
                            result_d = special_res;
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_d = step_next;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        result_d = final_res;
                        cnt_d    = '0;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d    = cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_CALC);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.RESULT_OUT = result_q;
    assign bus.DONE_OUT   = done_q;
    assign bus.BUSY_OUT   = busy_q;
    // Combinational so the freeze takes effect in the same cycle VALID_IN arrives
    assign bus.STALL_OUT  = rst & (((state_q == S_IDLE) & bus.VALID_IN) |
                                   (state_q == S_CALC));
endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.WIDTH(W)) bus ();

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          special;
    } vec_t;

    vec_t vecs[18];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.FUNCT3_IN = f3;
        bus.SRCA_IN   = a;
        bus.SRCB_IN   = b;
        bus.VALID_IN  = 1'b1;
    endtask

    // Cycle 0 is the cycle in which VALID_IN is first presented in IDLE.
    task automatic wait_done(output int done_cyc, output int stalls, output int busies,
                             output logic [31:0] res, output logic stall_at_done);
        done_cyc      = -1;
        stalls        = 0;
        busies        = 0;
        res           = '0;
        stall_at_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.DONE_OUT) begin
                done_cyc      = c;
                res           = bus.RESULT_OUT;
                stall_at_done = bus.STALL_OUT;
                bus.VALID_IN  = 1'b0;
                break;
            end
            if (bus.STALL_OUT) stalls++;
            if (bus.BUSY_OUT) busies++;
        end
    endtask

    task automatic check_op(input string nm, input logic [31:0] exp_res, input bit exp_special);
        int          dc, st, bz;
        logic [31:0] r;
        logic        sd;
        wait_done(dc, st, bz, r, sd);
        if (dc < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: no DONE_OUT within 100 cycles", nm);
        end else begin
            chk({nm, " result"}, r, exp_res);
            chk({nm, " done_cycle"}, dc, exp_special ? 1 : W + 1);
            chk({nm, " stall_cycles"}, st, exp_special ? 1 : W + 1);
            chk({nm, " busy_cycles"}, bz, exp_special ? 0 : W);
            chk({nm, " stall_in_done"}, {31'b0, sd}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] exp_res, last_res;
        bit          exp_sp;
        int          dones;

        vecs[0]  = '{"mul_7_m3",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{"mulhu_ff",      3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[2]  = '{"mulh_min",      3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
        vecs[3]  = '{"mulhsu_m1",     3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{"mulh_m2_3",     3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};
        vecs[5]  = '{"mulh_m1_m1",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[6]  = '{"mul_3_4",       3'd0, 32'd3,        32'd4,        32'd12,       1'b0};
        vecs[7]  = '{"div_m7_2",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{"rem_m7_2",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{"divu_100_7",    3'd5, 32'd100,      32'd7,        32'd14,       1'b0};
        vecs[10] = '{"remu_100_7",    3'd7, 32'd100,      32'd7,        32'd2,        1'b0};
        vecs[11] = '{"div_7_m2",      3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        vecs[12] = '{"rem_7_m2",      3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0};
        vecs[13] = '{"divu_min_ff",   3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0};
        vecs[14] = '{"div_by_0",      3'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[15] = '{"remu_by_0",     3'd7, 32'h1234,     32'd0,        32'h1234,     1'b1};
        vecs[16] = '{"rem_ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1};
        vecs[17] = '{"div_ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};

        bus.VALID_IN  = 1'b0;
        bus.FLUSH_IN  = 1'b0;
        bus.FUNCT3_IN = '0;
        bus.SRCA_IN   = '0;
        bus.SRCB_IN   = '0;
        last_res      = '0;

        #12;
        chk("reset result", bus.RESULT_OUT, 32'd0);
        chk("reset done",   {31'b0, bus.DONE_OUT},  32'd0);
        chk("reset busy",   {31'b0, bus.BUSY_OUT},  32'd0);
        chk("reset stall",  {31'b0, bus.STALL_OUT}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (vecs[i]) begin
`ifdef MULDIV_DIV_EN
            exp_res = vecs[i].res;
            exp_sp  = vecs[i].special;
`else
            exp_res = vecs[i].f3[2] ? 32'd0 : vecs[i].res;
            exp_sp  = vecs[i].f3[2];
`endif
            start_op(vecs[i].f3, vecs[i].a, vecs[i].b);
            check_op(vecs[i].name, exp_res, exp_sp);
            last_res = exp_res;
        end

        // Flush a DIVU in cycle 10: no completion, result untouched
        start_op(3'd5, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        bus.FLUSH_IN = 1'b1;
        bus.VALID_IN = 1'b0;
        @(posedge clk);
        #1;
        bus.FLUSH_IN = 1'b0;
        chk("flush busy",  {31'b0, bus.BUSY_OUT},  32'd0);
        chk("flush stall", {31'b0, bus.STALL_OUT}, 32'd0);
        chk("flush done",  {31'b0, bus.DONE_OUT},  32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.DONE_OUT) dones++;
        end
        chk("flush done_pulses", dones, 0);
        chk("flush result_kept", bus.RESULT_OUT, last_res);
        start_op(3'd0, 32'd3, 32'd4);
        check_op("mul_after_flush", 32'd12, 1'b0);

        // Async reset in cycle 20 of a MUL, then restart with VALID_IN held
        start_op(3'd0, 32'h10, 32'h20);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midop_rst result", bus.RESULT_OUT, 32'd0);
        chk("midop_rst done",   {31'b0, bus.DONE_OUT},  32'd0);
        chk("midop_rst busy",   {31'b0, bus.BUSY_OUT},  32'd0);
        chk("midop_rst stall",  {31'b0, bus.STALL_OUT}, 32'd0);
        bus.FUNCT3_IN = 3'd0;
        bus.SRCA_IN   = 32'd5;
        bus.SRCB_IN   = 32'd6;
        bus.VALID_IN  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_op("mul_after_rst", 32'd30, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage. It sits beside the ALU and drives the result mux that feeds the EX/MEM pipeline register. On a valid M-extension instruction it runs for WIDTH cycles and holds STALL_OUT high, which freezes IF/ID/EX. It then presents the result for exactly one cycle with STALL_OUT low, so the instruction advances into EX/MEM on that edge.

## Interface
- WIDTH, 32, operand/result width; must be even, ≥ 8.
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- VALID_IN  in  1  EX holds an M-extension instruction; held high by upstream while stalled.
- FLUSH_IN  in  1  synchronous abort of the current operation (branch/exception flush).
- FUNCT3_IN  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- SRCA_IN  in  WIDTH  rs1 operand (after forwarding).
- SRCB_IN  in  WIDTH  rs2 operand (after forwarding).
- RESULT_OUT  out  WIDTH  registered result, valid while DONE_OUT=1.
- DONE_OUT  out  1  one-cycle completion pulse.
- STALL_OUT  out  1  pipeline freeze request, combinational from state and inputs.
- BUSY_OUT  out  1  registered; high while in CALC.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, VALID_IN=1: latch the operands and FUNCT3.
  - Signed ops latch magnitudes plus result-sign flags.
  - Normal case: go to CALC with counter=0.
  - Special case: go straight to DONE with the preloaded result.
- Special cases:
  - Divisor = 0: DIV/DIVU give all ones; REM/REMU give the dividend.
  - Signed overflow (dividend = 1<<(WIDTH-1), divisor = all ones): DIV gives the dividend; REM gives 0.
- CALC, multiply: radix-2 shift-add, 2·WIDTH-bit product.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half after sign correction (two's-complement negate of the full product when the sign flag is set).
- CALC, divide: restoring shift-subtract, one quotient bit per cycle.
  - Quotient sign = signA XOR signB.
  - Remainder sign = signA.
- CALC counts 0..WIDTH-1. At count WIDTH-1 the sign fix is applied, RESULT_OUT is registered, and the state goes to DONE.
- DONE: DONE_OUT=1, then unconditionally IDLE. VALID_IN seen in DONE is not a new operation; the next instruction is sampled in the following IDLE cycle.
- STALL_OUT = rst & ((IDLE & VALID_IN) | CALC).
- FLUSH_IN=1 in any state forces IDLE next cycle.
  - DONE_OUT=0, RESULT_OUT unchanged.
  - FLUSH_IN overrides VALID_IN in IDLE.
- Reset, asserted any time including mid-CALC: state IDLE, RESULT_OUT=0, DONE_OUT=0, BUSY_OUT=0, counter=0, STALL_OUT=0.

## Timing
- VALID_IN first sampled high in IDLE at edge 0.
  - Normal: STALL_OUT high from cycle 0 through cycle WIDTH (WIDTH+1 stall cycles).
  - DONE_OUT/RESULT_OUT valid in cycle WIDTH+1 with STALL_OUT=0; EX/MEM captures at the end of that cycle.
- Special case: STALL_OUT high in cycle 0 only; DONE in cycle 1.
- Throughput: back-to-back ops need one IDLE cycle between DONE and the next start.
- All state, counter and data registers update on posedge clk; reset is async to them.

## Configuration
- MULDIV_DIV_EN defined: full unit as above.
- MULDIV_DIV_EN undefined:
  - Divider datapath and special-case logic are removed.
  - FUNCT3_IN[2]=1 goes IDLE→DONE with RESULT_OUT=0 and a single stall cycle.
  - Multiply ops are unchanged.

## Test plan
- MUL, SRCA=7, SRCB=0xFFFFFFFD: STALL 33 cycles; DONE in cycle 33 with RESULT_OUT=0xFFFFFFEB.
- MULHU, 0xFFFFFFFF×0xFFFFFFFF: RESULT_OUT=0xFFFFFFFE. MULH, 0x80000000×0x80000000: RESULT_OUT=0x40000000.
- DIV, −7/2: RESULT_OUT=0xFFFFFFFD. REM, −7/2: RESULT_OUT=0xFFFFFFFF. DIVU, 100/7: RESULT_OUT=14.
- DIV by 0: DONE in cycle 1 with RESULT_OUT=0xFFFFFFFF. REM 0x80000000/0xFFFFFFFF: DONE in cycle 1 with RESULT_OUT=0.
- Start DIVU, pulse FLUSH_IN in cycle 10: IDLE next cycle, STALL_OUT=0, no DONE pulse. A subsequent MUL 3×4 returns 12.
- Drop rst in cycle 20 of a MUL: all outputs 0 immediately. Release rst with VALID_IN=1: a fresh 33-cycle operation starts.
